// File: rtl/breakout_pkg.sv
// ============================================================================
// breakout_pkg : shared button indices and debounce FSM state encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package breakout_pkg;

  localparam int BTN_DISP  = 0;
  localparam int BTN_LEFT  = 1;
  localparam int BTN_RIGHT = 2;

  typedef enum logic [1:0] {
    UP       = 2'd0,
    UP_CHK   = 2'd1,
    DOWN     = 2'd2,
    DOWN_CHK = 2'd3
  } btnState_t;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
// ============================================================================
// debounce_channel : one-bit synchronizer, debounce FSM and auto-repeat timer
// Rev 1.0
// ============================================================================
`default_nettype none

module debounce_channel
  import breakout_pkg::*;
#(
  parameter int DB_CYCLES     = 500000,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic clock,
  input  logic reset,
  input  logic rawN,
  output logic btnN,
  output logic press,
  output logic release_,
  output logic repeat_
);

  localparam int DB_W     = $clog2(DB_CYCLES + 1);
  localparam int HOLD_MAX = maxInt(HOLD_CYCLES, REPEAT_CYCLES);
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

  localparam logic [DB_W-1:0]   c_dbLast     = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] c_holdLast   = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_W-1:0] c_repeatLast = HOLD_W'(REPEAT_CYCLES - 1);

  logic              r_s1;
  logic              r_s2;
  btnState_t         r_state;
  btnState_t         w_nextState;
  logic [DB_W-1:0]   r_dbCnt;
  logic [DB_W-1:0]   w_dbCnt;
  logic [HOLD_W-1:0] r_holdCnt;
  logic [HOLD_W-1:0] w_holdCnt;
  logic              r_repeating;
  logic              w_repeating;
  logic              r_btnN;
  logic              w_btnN;
  logic              r_press;
  logic              w_press;
  logic              r_release;
  logic              w_release;
  logic              r_repeat;
  logic              w_repeat;
  logic [HOLD_W-1:0] w_holdLast;
  logic              w_holdTick;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s1        <= 1'b1;
      r_s2        <= 1'b1;
      r_state     <= UP;
      r_dbCnt     <= '0;
      r_holdCnt   <= '0;
      r_repeating <= 1'b0;
      r_btnN      <= 1'b1;
      r_press     <= 1'b0;
      r_release   <= 1'b0;
      r_repeat    <= 1'b0;
    end else begin
      r_s1        <= rawN;
      r_s2        <= r_s1;
      r_state     <= w_nextState;
      r_dbCnt     <= w_dbCnt;
      r_holdCnt   <= w_holdCnt;
      r_repeating <= w_repeating;
      r_btnN      <= w_btnN;
      r_press     <= w_press;
      r_release   <= w_release;
      r_repeat    <= w_repeat;
    end
  end

  // First interval after a press is HOLD_CYCLES, every later one REPEAT_CYCLES.
  assign w_holdLast = r_repeating ? c_repeatLast : c_holdLast;
  assign w_holdTick = (r_holdCnt == w_holdLast);

  always_comb begin
    w_nextState = r_state;
    w_dbCnt     = r_dbCnt;
    w_holdCnt   = r_holdCnt;
    w_repeating = r_repeating;
    w_btnN      = r_btnN;
    w_press     = 1'b0;
    w_release   = 1'b0;
    w_repeat    = 1'b0;

    case (r_state)
      UP: begin
        w_holdCnt   = '0;
        w_repeating = 1'b0;
        if (!r_s2) begin
          w_nextState = UP_CHK;
          w_dbCnt     = '0;
        end
      end

      UP_CHK: begin
        w_holdCnt   = '0;
        w_repeating = 1'b0;
        if (r_s2) begin
          w_nextState = UP;
        end else if (r_dbCnt == c_dbLast) begin
          w_nextState = DOWN;
          w_btnN      = 1'b0;
          w_press     = 1'b1;
        end else begin
          w_dbCnt = r_dbCnt + 1'b1;
        end
      end

      DOWN, DOWN_CHK: begin
        // The hold timer keeps running through release bounces.
        if (w_holdTick) begin
          w_repeat    = 1'b1;
          w_holdCnt   = '0;
          w_repeating = 1'b1;
        end else begin
          w_holdCnt = r_holdCnt + 1'b1;
        end

        if (r_state == DOWN) begin
          if (r_s2) begin
            w_nextState = DOWN_CHK;
            w_dbCnt     = '0;
          end
        end else if (!r_s2) begin
          w_nextState = DOWN;
        end else if (r_dbCnt == c_dbLast) begin
          // Accepted release suppresses any repeat due on the same edge.
          w_nextState = UP;
          w_btnN      = 1'b1;
          w_release   = 1'b1;
          w_repeat    = 1'b0;
          w_holdCnt   = '0;
          w_repeating = 1'b0;
        end else begin
          w_dbCnt = r_dbCnt + 1'b1;
        end
      end

      default: begin
        w_nextState = UP;
      end
    endcase
  end

  assign btnN     = r_btnN;
  assign press    = r_press;
  assign release_ = r_release;
  assign repeat_  = r_repeat;

endmodule

`default_nettype wire

// File: rtl/button_conditioner.sv
// ============================================================================
// button_conditioner : debounced levels and press/release/repeat strobes
// for the active-low board push-buttons. Rev 1.0
// ============================================================================
`default_nettype none

module button_conditioner
  import breakout_pkg::*;
#(
  parameter int N_BTN         = 3,
  parameter int DB_CYCLES     = 500000,
  parameter int HOLD_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw_n,
  output logic [N_BTN-1:0] btn_n,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] release_,
  output logic [N_BTN-1:0] repeat_
);

  if (N_BTN < 1) begin : g_badNBtn
    $fatal(1, "button_conditioner: N_BTN must be >= 1");
  end
  if (DB_CYCLES < 1) begin : g_badDb
    $fatal(1, "button_conditioner: DB_CYCLES must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_badHold
    $fatal(1, "button_conditioner: HOLD_CYCLES must be >= 1");
  end
  if (REPEAT_CYCLES < 1) begin : g_badRepeat
    $fatal(1, "button_conditioner: REPEAT_CYCLES must be >= 1");
  end

  for (genvar i = 0; i < N_BTN; i++) begin : g_channel
    debounce_channel #(
      .DB_CYCLES    (DB_CYCLES),
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_channel (
      .clock   (clock),
      .reset   (reset),
      .rawN    (btn_raw_n[i]),
      .btnN    (btn_n[i]),
      .press   (press[i]),
      .release_(release_[i]),
      .repeat_ (repeat_[i])
    );
  end

endmodule

`default_nettype wire

// File: doc/button_conditioner.md
# button_conditioner

Conditions the raw, active-low board push-buttons (display, left, right) before they reach the game core. Each channel has a two-flop synchronizer and a debounce state machine. It outputs a clean active-low level that drops directly into the game core's existing `disp`/`left`/`right` inputs. It also emits single-cycle press, release and auto-repeat strobes for menu and score logic. Runs on the board clock, ahead of the pixel-clock divider.

## Interface
- `N_BTN`, 3: number of channels. Bit 0 = disp, 1 = left, 2 = right.
- `DB_CYCLES`, 500000: stable cycles required to accept a level change (10 ms at 50 MHz). Must be ≥1.
- `HOLD_CYCLES`, 25000000: cycles from press strobe to first repeat strobe. Must be ≥1.
- `REPEAT_CYCLES`, 5000000: cycles between later repeat strobes. Must be ≥1.

Ports (clock and reset first):
- `clock` in 1: board clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `btn_raw_n` in N_BTN: asynchronous raw buttons, 0 = pressed.
- `btn_n` out N_BTN: debounced level, 0 = pressed.
- `press` out N_BTN: one-cycle strobe on accepted press.
- `release` out N_BTN: one-cycle strobe on accepted release.
- `repeat` out N_BTN: one-cycle auto-repeat strobe while held.

## Operation
- Synchronizer: `s1 <= btn_raw_n`, `s2 <= s1`. Both reset to all-ones.
- Channels are fully independent and operate simultaneously with no priority.
- Per-channel FSM states are UP, UP_CHK, DOWN, DOWN_CHK. Debounce counter `db_cnt` is $clog2(DB_CYCLES+1) bits.
  - UP: if `s2`=0, go to UP_CHK and set `db_cnt`←0.
  - UP_CHK: if `s2`=1, return to UP (bounce rejected, no output change).
    - Else if `db_cnt`==DB_CYCLES−1: go to DOWN, `btn_n`←0, `press`←1, `hold_cnt`←0.
    - Else `db_cnt`++.
  - DOWN: if `s2`=1, go to DOWN_CHK and set `db_cnt`←0.
  - DOWN_CHK: if `s2`=0, return to DOWN.
    - Else if `db_cnt`==DB_CYCLES−1: go to UP, `btn_n`←1, `release`←1.
    - Else `db_cnt`++.
- Hold counter `hold_cnt` runs in DOWN and DOWN_CHK. A release bounce does not restart it.
  - First `repeat` comes HOLD_CYCLES cycles after the `press` cycle.
  - Later strobes come every REPEAT_CYCLES cycles after that.
  - The counter reloads on each strobe and never wraps uncontrolled.
  - It is cleared in UP and UP_CHK.
- Strobes are registered and last exactly one cycle. `press` and `release` never assert together on one channel.
- Reset values:
  - State UP on all channels.
  - `btn_n`=all-ones; `press`, `release`, `repeat`=0.
  - Counters 0; `s1`, `s2`=all-ones.
- Reset mid-operation: reset wins over every transition and no strobe is emitted. A button still held when reset deasserts is re-qualified from UP and produces a fresh `press`.

## Timing
- Edge numbering: edge 0 is the first edge at which `s1` samples the new raw level.
  - `s2` changes at edge 1.
  - The FSM leaves UP/DOWN at edge 2.
  - `btn_n` and the strobe update at edge DB_CYCLES+2.
- Total raw-to-output latency is DB_CYCLES+3 edges, counted from edge 0 through edge DB_CYCLES+2 inclusive.
- Bounce rule: the level is accepted only if it stays stable for DB_CYCLES consecutive FSM samples. Any opposite sample restarts qualification from the idle state.
- `repeat` fires at P+HOLD_CYCLES, then P+HOLD_CYCLES+k·REPEAT_CYCLES, where P is the `press` cycle.
- `repeat` can coincide with the DOWN_CHK entry. It cannot coincide with `release`: the hold counter is cleared on the same edge.

## Structure
- Shared package `breakout_pkg` holds:
  - `BTN_DISP`=0, `BTN_LEFT`=1, `BTN_RIGHT`=2.
  - The 2-bit state encoding: UP=0, UP_CHK=1, DOWN=2, DOWN_CHK=3.
- One sub-module, `debounce_channel`, contains the single-bit synchronizer, FSM and counters. The top instantiates it N_BTN times in a generate loop.
- Parameter legality is checked at elaboration; any value <1 is a fatal error.

## Test plan
Bench parameters: DB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3.
- Reset held for 3 cycles with raw=3'b000:
  - During reset, `btn_n`=3'b111 and all strobes are 0.
  - After release, `btn_n`=3'b000 at edge 6 and `press`=3'b111 for one cycle.
- Clean press on left (raw[1] low from edge 0): `btn_n[1]` falls at edge 6, `press[1]` is high only in the cycle after edge 6, and other channels are untouched.
- Bounce on left (raw[1] low 3 cycles, high 1, low 2, high): no `press`, `btn_n[1]` stays 1.
- Hold right (press strobe cycle P): `repeat[2]` at P+10, P+13, P+16. No `repeat` after the accepted release.
- Release with one-cycle glitch back to pressed in DOWN_CHK: `release` is delayed until 4 stable samples after the glitch, and the `repeat` cadence is unbroken.
- Left and right pressed on the same edge: identical `press` timing on bits 1 and 2. Then `reset` asserted mid-UP_CHK on disp produces no strobe and `btn_n[0]`=1.
